// File: rtl/uart_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_stream_ctrl                                               |
// | Brief   : Bridges a TX/RX byte stream pair onto the uart_core register   |
// |           port: writes CR once after reset, then polls STATUS and moves  |
// |           bytes through DATA with one-entry RX buffering.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_stream_ctrl #(
  parameter logic [31:0] CR_VALUE = 32'h0000_0003,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [7:0]  tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [7:0]  rx_data_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  output logic [3:0]  reg_be_o,
  input  logic [31:0] reg_rdata_i,
  output logic        cfg_done_o,
  output logic        busy_o
);

  localparam logic [31:0] C_ADDR_DATA   = 32'h0000_0000;
  localparam logic [31:0] C_ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] C_ADDR_CR     = 32'h0000_0008;
  localparam logic [15:0] C_GAP_LOAD    = 16'(POLL_GAP);

  typedef enum logic [2:0] {
    CFG_WR    = 3'd0,
    IDLE      = 3'd1,
    POLL_RD   = 3'd2,
    POLL_WAIT = 3'd3,
    TX_WR     = 3'd4,
    RX_RD     = 3'd5,
    RX_WAIT   = 3'd6,
    GAP       = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic        cfg_pend_q;
  logic [15:0] gap_q, gap_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        reg_we_q, reg_we_d;
  logic        reg_re_q, reg_re_d;
  logic [31:0] reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic [3:0]  reg_be_q, reg_be_d;
  logic        tx_ready_q, tx_ready_d;
  logic        cfg_done_q, cfg_done_d;
  logic        busy_q, busy_d;

  // Only the low status/data byte of the core read data is meaningful here
  logic unused_rdata;
  assign unused_rdata = ^reg_rdata_i[31:8];

  // Next-state decision; en=0 diverts to IDLE wherever a poll or gap would start
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      // A pending CR write is issued first, then the FSM settles in IDLE
      CFG_WR:    state_d = cfg_pend_q ? CFG_WR : IDLE;
      IDLE:      if (en_i) state_d = POLL_RD;
      POLL_RD:   state_d = POLL_WAIT;
      POLL_WAIT: begin
        // RX first so the core's receiver cannot overrun; buffer check uses pre-edge state
        if (reg_rdata_i[0] && !rx_valid_q) begin
          state_d = RX_RD;
        end else if (tx_valid_i && !reg_rdata_i[1]) begin
          state_d = TX_WR;
        end else begin
          state_d = en_i ? GAP : IDLE;
          gap_d   = C_GAP_LOAD;
        end
      end
      TX_WR:     state_d = en_i ? POLL_RD : IDLE;
      RX_RD:     state_d = RX_WAIT;
      RX_WAIT:   state_d = en_i ? POLL_RD : IDLE;
      GAP: begin
        if (gap_q == 16'd0) begin
          state_d = en_i ? POLL_RD : IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // One-entry RX buffer: a consume clears it, the RX_WAIT capture refills it
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (state_q == RX_WAIT) begin
      rx_valid_d = 1'b1;
      rx_data_d  = reg_rdata_i[7:0];
    end
  end

  // Port drive for the cycle being entered, so every output comes straight from a flop
  always_comb begin
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    reg_addr_d  = '0;
    reg_wdata_d = '0;
    reg_be_d    = '0;
    tx_ready_d  = 1'b0;
    case (state_d)
      CFG_WR: begin
        reg_we_d    = 1'b1;
        reg_addr_d  = C_ADDR_CR;
        reg_wdata_d = CR_VALUE;
        reg_be_d    = 4'hF;
      end
      POLL_RD: begin
        reg_re_d   = 1'b1;
        reg_addr_d = C_ADDR_STATUS;
        reg_be_d   = 4'hF;
      end
      TX_WR: begin
        reg_we_d    = 1'b1;
        reg_addr_d  = C_ADDR_DATA;
        reg_wdata_d = {24'h0, tx_data_i};
        reg_be_d    = 4'hF;
        tx_ready_d  = 1'b1;
      end
      RX_RD: begin
        reg_re_d   = 1'b1;
        reg_addr_d = C_ADDR_DATA;
        reg_be_d   = 4'hF;
      end
      default: ;
    endcase
    cfg_done_d = cfg_done_q || ((state_q == CFG_WR) && !cfg_pend_q);
    busy_d     = (state_d != IDLE) && (state_d != GAP);
  end

  // State, buffer and output flops; reset leaves a CR write pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CFG_WR;
      cfg_pend_q  <= 1'b1;
      gap_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
      tx_ready_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_pend_q  <= 1'b0;
      gap_q       <= gap_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      tx_ready_q  <= tx_ready_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ready_o  = tx_ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign reg_be_o    = reg_be_q;
  assign cfg_done_o  = cfg_done_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_stream_ctrl                                            |
// | Brief   : Scoreboard bench for uart_stream_ctrl with a mock uart_core    |
// |           (STATUS/DATA/CR, TX-full timer, TX->RX loopback).              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_stream_ctrl;

  localparam int unsigned POLL_GAP = 4;
  localparam logic [31:0] CR_VALUE = 32'h0000_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        cfg_done;
  logic        busy;

  always #5 clk = ~clk;

  uart_stream_ctrl #(.CR_VALUE(CR_VALUE), .POLL_GAP(POLL_GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
    .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we),
    .reg_re_o(reg_re), .reg_be_o(reg_be), .reg_rdata_i(reg_rdata),
    .cfg_done_o(cfg_done), .busy_o(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_fifo[$];
  logic [7:0] lb_data[$];
  int         lb_due[$];
  int         last_due = 0;
  int         tx_full_cnt = 0;
  int         cfg_wr_cnt = 0, rd0_cnt = 0, wr0_cnt = 0, acc_cnt = 0;
  int         poll_cyc[$];
  int         acc_log[$];     // 1 = DATA read, 2 = DATA write, 3 = STATUS read
  logic       tx_hs_seen = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h0;
  logic       rnd_mode = 1'b0;
  logic [7:0] mon_b;
  int         mon_due;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Mock uart_core plus monitor/scoreboard, all evaluated away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cyc++;
      while (lb_due.size() > 0 && lb_due[0] <= cyc) begin
        void'(lb_due.pop_front());
        mon_b = lb_data.pop_front();
        rx_fifo.push_back(mon_b);
        rx_exp.push_back(mon_b);
      end
      if (reg_we || reg_re) begin
        acc_cnt++;
        check("access_be", 32'(reg_be), 32'hF);
        check("we_re_exclusive", 32'(reg_we & reg_re), 32'h0);
        if (reg_we && reg_addr == 32'h8) begin
          cfg_wr_cnt++;
          check("cr_wdata", reg_wdata, CR_VALUE);
        end else if (reg_we && reg_addr == 32'h0) begin
          wr0_cnt++;
          acc_log.push_back(2);
          check("write_while_tx_full", 32'(tx_full_cnt > 0), 32'h0);
          check("tx_ready_valid_in_write", {30'h0, tx_ready, tx_valid}, 32'h3);
          if (tx_exp.size() == 0) check("tx_unexpected_write", 32'h1, 32'h0);
          else check("tx_byte", reg_wdata, {24'h0, tx_exp.pop_front()});
          tx_hs_seen  = 1'b1;
          tx_full_cnt = int'($urandom_range(0, 10));
          mon_due = cyc + int'($urandom_range(8, 30));
          if (mon_due <= last_due) mon_due = last_due + 1;
          last_due = mon_due;
          lb_data.push_back(reg_wdata[7:0]);
          lb_due.push_back(mon_due);
        end else if (reg_re && reg_addr == 32'h4) begin
          poll_cyc.push_back(cyc);
          acc_log.push_back(3);
          reg_rdata = {30'h0, tx_full_cnt > 0, rx_fifo.size() > 0};
        end else if (reg_re && reg_addr == 32'h0) begin
          rd0_cnt++;
          acc_log.push_back(1);
          if (rx_fifo.size() == 0) begin
            check("data_read_when_empty", 32'h1, 32'h0);
            reg_rdata = 32'h0;
          end else begin
            reg_rdata = {24'h0, rx_fifo.pop_front()};
          end
        end else begin
          check("access_address", reg_addr, 32'hFFFF_FFFF);
        end
      end else begin
        check("idle_port", reg_addr | reg_wdata | {28'h0, reg_be}, 32'h0);
        check("tx_ready_outside_write", 32'(tx_ready), 32'h0);
      end
      if (prev_hold) begin
        check("rx_hold_valid", 32'(rx_valid), 32'h1);
        check("rx_hold_data", 32'(rx_data), 32'(prev_data));
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) check("rx_unexpected_byte", 32'h1, 32'h0);
        else check("rx_byte", 32'(rx_data), 32'(rx_exp.pop_front()));
        prev_hold = 1'b0;
      end else begin
        prev_hold = rx_valid;
      end
      prev_data = rx_data;
      if (tx_full_cnt > 0) tx_full_cnt--;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 15) != 0);
    end
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while (!tx_hs_seen && n < 600) begin
      tick();
      n++;
    end
    check(name, 32'(tx_hs_seen), 32'h1);
    tx_hs_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_exp.push_back(b);
    tx_valid   = 1'b1;
    tx_data    = b;
    tx_hs_seen = 1'b0;
    wait_tx("tx_handshake");
  endtask

  task automatic drain();
    int n = 0;
    while ((rx_exp.size() + lb_data.size() + rx_fifo.size()) > 0 && n < 2000) begin
      tick();
      n++;
    end
    check("drain_remaining", 32'(rx_exp.size() + lb_data.size() + rx_fifo.size()), 32'h0);
  endtask

  task automatic inject(input logic [7:0] b);
    rx_fifo.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic reset_and_check(input string name);
    int c0;
    c0 = cfg_wr_cnt;
    rst_n = 1'b0;
    #1;
    check({name, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({name, "_rx_data"}, 32'(rx_data), 32'h0);
    check({name, "_port"}, {30'h0, reg_we, reg_re} | reg_addr | reg_wdata, 32'h0);
    check({name, "_flags"}, {29'h0, tx_ready, cfg_done, busy}, 32'h0);
    if (rx_exp.size() > 0) void'(rx_exp.pop_front());
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check({name, "_cr_rewrite"}, 32'(cfg_wr_cnt - c0), 32'h1);
    check({name, "_cfg_done"}, 32'(cfg_done), 32'h1);
  endtask

  initial begin
    int n, c0, lat;
    rst_n = 1'b0; en = 1'b0; tx_valid = 1'b0; tx_data = 8'h0; rx_ready = 1'b0; reg_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_port", {30'h0, reg_we, reg_re} | reg_addr | reg_wdata | {28'h0, reg_be}, 32'h0);
    check("reset_flags", {27'h0, tx_ready, rx_valid, cfg_done, busy, 1'b0}, 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);

    // Release mid-cycle; the CR write appears in the cycle after the first edge
    en = 1'b1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("cfg_write_we", {31'h0, reg_we}, 32'h1);
    check("cfg_write_addr", reg_addr, 32'h8);
    check("cfg_write_data", reg_wdata, CR_VALUE);
    check("cfg_done_during_write", 32'(cfg_done), 32'h0);
    tick();
    check("cfg_done_after_write", 32'(cfg_done), 32'h1);

    // Idle polling period
    repeat (10) tick();
    poll_cyc.delete();
    repeat (40) tick();
    check("idle_poll_count_ge4", 32'(poll_cyc.size() >= 4), 32'h1);
    for (int i = 1; i < poll_cyc.size(); i++)
      check("idle_poll_period", 32'(poll_cyc[i] - poll_cyc[i-1]), POLL_GAP + 3);
    check("cfg_single_write", 32'(cfg_wr_cnt), 32'h1);

    // Single byte round trip
    c0 = wr0_cnt;
    send_byte(8'hA5);
    tx_valid = 1'b0;
    drain();
    check("a5_single_write", 32'(wr0_cnt - c0), 32'h1);

    // Best-case latency from IDLE
    en = 1'b0;
    repeat (20) tick();
    tx_exp.push_back(8'h3C);
    tx_valid = 1'b1; tx_data = 8'h3C; en = 1'b1; tx_hs_seen = 1'b0;
    lat = 0;
    while (!(reg_we && reg_addr == 32'h0) && lat < 20) begin
      tick();
      lat++;
    end
    check("idle_to_tx_latency", 32'(lat), 32'h3);
    wait_tx("latency_handshake");
    tx_valid = 1'b0;
    drain();

    // Back-to-back burst
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    tx_valid = 1'b0;
    drain();

    // Randomized traffic with random consumer backpressure and enable drops
    rnd_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send_byte(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(1, 15)) tick();
      end
    end
    tx_valid = 1'b0;
    rnd_mode = 1'b0;
    en = 1'b1;
    rx_ready = 1'b1;
    drain();

    // RX before TX when STATUS reads 0x3
    en = 1'b0;
    repeat (20) tick();
    inject(8'hC3);
    tx_full_cnt = 20;
    tx_exp.push_back(8'h77);
    tx_valid = 1'b1; tx_data = 8'h77; tx_hs_seen = 1'b0;
    acc_log.delete();
    en = 1'b1;
    n = 0;
    while (acc_log.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    check("prio_access_count", 32'(acc_log.size() >= 2), 32'h1);
    if (acc_log.size() >= 2) begin
      check("prio_first_poll", 32'(acc_log[0]), 32'h3);
      check("prio_rx_before_tx", 32'(acc_log[1]), 32'h1);
    end
    wait_tx("prio_tx_handshake");
    tx_valid = 1'b0;
    drain();

    // Held RX byte defers further DATA reads
    rx_ready = 1'b0;
    inject(8'h11);
    inject(8'h22);
    n = 0;
    while (!rx_valid && n < 40) begin
      tick();
      n++;
    end
    check("held_rx_data", 32'(rx_data), 32'h11);
    c0 = rd0_cnt;
    repeat (40) tick();
    check("no_read_while_full", 32'(rd0_cnt - c0), 32'h0);
    check("held_still_11", {23'h0, rx_valid, rx_data}, 32'h111);
    rx_ready = 1'b1;
    n = 0;
    while (rd0_cnt == c0 && n < 30) begin
      tick();
      n++;
    end
    check("read_after_consume", 32'(rd0_cnt - c0), 32'h1);
    drain();

    // Dropping en during TX_WR completes the write, then goes quiet
    tx_exp.push_back(8'h42);
    tx_valid = 1'b1; tx_data = 8'h42; tx_hs_seen = 1'b0;
    n = 0;
    while (!tx_ready && n < 60) begin
      tick();
      n++;
    end
    en = 1'b0;
    tick();
    check("en_drop_write_done", 32'(tx_hs_seen), 32'h1);
    tx_hs_seen = 1'b0;
    tx_valid = 1'b0;
    c0 = acc_cnt;
    repeat (30) tick();
    check("en_drop_no_access", 32'(acc_cnt - c0), 32'h0);
    check("en_drop_not_busy", 32'(busy), 32'h0);
    check("en_drop_tx_queue", 32'(tx_exp.size()), 32'h0);
    en = 1'b1;
    drain();

    // Reset during RX_WAIT loses the in-flight byte and rewrites CR
    inject(8'h5E);
    n = 0;
    while (!(reg_re && reg_addr == 32'h0) && n < 40) begin
      tick();
      n++;
    end
    tick();
    reset_and_check("rst_rx_wait");

    // Reset while a byte is held discards it
    rx_ready = 1'b0;
    inject(8'h66);
    n = 0;
    while (!rx_valid && n < 40) begin
      tick();
      n++;
    end
    check("held_66", 32'(rx_data), 32'h66);
    reset_and_check("rst_held");
    rx_ready = 1'b1;

    // Final traffic after reset
    send_byte(8'h99);
    tx_valid = 1'b0;
    drain();
    check("final_tx_queue", 32'(tx_exp.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_stream_ctrl.md
UART_STREAM_CTRL -- requirements
Module: uart_stream_ctrl

Interface
REQ-001 SHALL have parameter CR_VALUE, default 32'h0000_0003, the value written to the uart_core CR (0x08): TX_EN, RX_EN, 8N1.
REQ-002 SHALL have parameter POLL_GAP, default 16, the number of idle cycles between status polls when there is no work; 0 means re-poll immediately.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  enables polling and transfers.
REQ-006 tx_valid / tx_ready / tx_data  in / out / in  1/1/8  byte stream to transmit.
REQ-007 rx_valid / rx_ready / rx_data  out / in / out  1/1/8  received byte stream.
REQ-008 reg_addr, reg_wdata  out  32 each  register-port master toward uart_core.
REQ-009 reg_we, reg_re  out  1 each  write strobe, read strobe.
REQ-010 reg_be  out  4  byte enables.
REQ-011 reg_rdata  in  32  uart_core read data; valid in the cycle after the reg_re cycle.
REQ-012 cfg_done  out  1  CR write completed.
REQ-013 busy  out  1  state is not IDLE or GAP.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The register map used SHALL be: 0x00 DATA (write = TX byte, read = RX byte); 0x04 STATUS (bit0 RX ready, bit1 TX full); 0x08 CR.
REQ-016 Outside access cycles the port SHALL idle at: we=0, re=0, be=0, addr=0, wdata=0.
REQ-017 Every access SHALL last exactly one cycle with be=4'hF.
REQ-018 The FSM SHALL have exactly these states: CFG_WR, IDLE, POLL_RD, POLL_WAIT, TX_WR, RX_RD, RX_WAIT, GAP.
REQ-019 In the first cycle after reset release, the block SHALL be in CFG_WR and drive we=1, addr=0x08, wdata=CR_VALUE; next state IDLE, and cfg_done SHALL be 1 from then on.
REQ-020 IDLE SHALL go to POLL_RD when en=1 and stay in IDLE otherwise.
REQ-021 POLL_RD SHALL drive re=1, addr=0x04, then go to POLL_WAIT.
REQ-022 POLL_WAIT SHALL sample reg_rdata at the end of the cycle and decide, in priority order:
- status bit0=1 and rx buffer empty -> RX_RD.
- tx_valid=1 and status bit1=0 -> TX_WR.
- otherwise -> GAP.
- RX has priority over TX to avoid overrun.
REQ-023 TX_WR SHALL drive we=1, addr=0x00, wdata={24'h0, tx_data} and tx_ready=1 for that cycle only; the byte transfers in that cycle; next state POLL_RD.
REQ-024 tx_ready SHALL be 0 in every other state.
REQ-025 RX_RD SHALL drive re=1, addr=0x00; the following RX_WAIT cycle SHALL capture reg_rdata[7:0] into rx_data and set rx_valid=1 at its end; next state POLL_RD.
REQ-026 The rx buffer SHALL hold one entry: rx_valid/rx_data stay stable until rx_valid&&rx_ready, which clears rx_valid at that edge.
REQ-027 While the rx buffer is full, RX reads SHALL be deferred; TX writes SHALL continue.
REQ-028 The rx-buffer-empty decision in POLL_WAIT SHALL use the pre-edge value; a consume on the same edge takes effect on the next poll.
REQ-029 GAP SHALL count a 16-bit counter, loaded with POLL_GAP, down to 0, then go to POLL_RD; with POLL_GAP=0 it SHALL spend one cycle in GAP.
REQ-030 Any new tx_valid arriving during GAP SHALL be serviced no earlier than the next poll.
REQ-031 en=0 SHALL never abort a started access: POLL_RD/RX_RD SHALL complete their WAIT cycle, and TX_WR SHALL complete its cycle.
REQ-032 With en=0, at the next POLL_RD or GAP entry the block SHALL go to IDLE instead; a pending rx byte stays held.
REQ-033 Best-case latency from tx_valid rising in IDLE (en=1) to the TX write cycle SHALL be 3 cycles (IDLE, POLL_RD, POLL_WAIT, then TX_WR).

Reset
REQ-034 rst_n low SHALL immediately force: state CFG_WR-pending, reg port idle values, tx_ready=0, rx_valid=0, rx_data=0, cfg_done=0, busy=0, gap counter=0.
REQ-035 rst_n low SHALL discard any held rx byte and abort any in-flight access.
REQ-036 After every reset release the CR SHALL be written again per REQ-019.

Verification
REQ-037 Reset release, en=1, uart_core (DEFAULT_BAUD_DIV 27) with txd looped to rxd -> one write addr 0x08 data 0x3 in cycle 1, cfg_done=1 thereafter, then periodic reads of 0x04 every POLL_GAP+3 cycles.
REQ-038 Push tx_data 0xA5 with rx_ready=1 -> exactly one write of 0x00 with 0xA5, then rx_valid with rx_data=0xA5 after roughly one frame time.
REQ-039 Push 0x00, 0xFF, 0x5A back-to-back -> received in order 0x00, 0xFF, 0x5A; no write occurs while STATUS bit1=1.
REQ-040 Mock core returning STATUS 0x3 with tx_valid=1 and rx buffer empty -> RX_RD is issued before TX_WR.
REQ-041 Mock STATUS 0x1, rx_ready=0 with byte 0x11 held -> no further reads of 0x00 and rx_data stays 0x11; raise rx_ready -> 0x11 consumed, and the next poll reads 0x00.
REQ-042 Drop en during TX_WR -> the write completes, then IDLE with no further accesses.
REQ-043 Assert rst_n low mid-RX_WAIT -> rx_valid=0 immediately, and the CR is rewritten after release.
